c_result_collector: RTL and testbench

Downstream sink for the matrix compute stage's AXI-Stream C output. Accepts one 2x2 result tile per arm, checks the tile length against the tlast position, and holds the beats in a register bank for readback by the control side. Flags tile completion or length errors, and counts completed tiles.

---
 rtl/c_result_collector.sv | 123 ++++++++++++
 tb/tb_c_result_collector.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/c_result_collector.sv
// c_result_collector: sink for one 2x2 C-result tile per arm, with length checking and a readback bank.
// Optional stall timeout in COLLECT/DRAIN is enabled by defining C_COLLECT_TIMEOUT_EN.
module c_result_collector #(
    parameter int DATA_W      = 32,
    parameter int NUM_BEATS   = 4,
    parameter int CNT_W       = 16,
    parameter int TIMEOUT_CYC = 1024
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [DATA_W-1:0]            s_axis_c_tdata,
    input  logic                         s_axis_c_tvalid,
    output logic                         s_axis_c_tready,
    input  logic                         s_axis_c_tlast,
    input  logic                         arm,
    input  logic                         ack,
    input  logic [$clog2(NUM_BEATS)-1:0] rd_addr,
    output logic [DATA_W-1:0]            rd_data,
    output logic                         tile_done,
    output logic                         err,
    output logic [1:0]                   err_code,
    output logic [CNT_W-1:0]             tile_cnt
);
    localparam int AW = $clog2(NUM_BEATS);

    typedef enum logic [2:0] {IDLE, COLLECT, HOLD, DRAIN, ERROR} state_t;

    state_t            state, state_next;
    logic [AW-1:0]     beat_cnt;
    logic [DATA_W-1:0] bank [NUM_BEATS];
    logic [1:0]        code_next;
    logic              active, hs, last_beat, timeout;

    assign active          = (state == COLLECT) || (state == DRAIN);
    assign s_axis_c_tready = active;
    assign hs              = active && s_axis_c_tvalid;
    assign last_beat       = beat_cnt == AW'(NUM_BEATS - 1);
    assign tile_done       = state == HOLD;
    assign err             = state == ERROR;

`ifdef C_COLLECT_TIMEOUT_EN
    localparam int SW = $clog2(TIMEOUT_CYC + 1);
    logic [SW-1:0] stall_cnt;
    assign timeout = active && !hs && (stall_cnt == SW'(TIMEOUT_CYC - 1));
    // Counts consecutive idle cycles; any handshake or state change restarts it
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            stall_cnt <= '0;
        else if (!active || hs || state_next != state)
            stall_cnt <= '0;
        else
            stall_cnt <= stall_cnt + SW'(1);
    end
`else
    assign timeout = 1'b0;
`endif

    always_comb begin
        state_next = state;
        code_next  = err_code;
        case (state)
            IDLE:    if (arm) state_next = COLLECT;
            COLLECT: begin
                if (hs && s_axis_c_tlast) begin
                    state_next = last_beat ? HOLD : ERROR;
                    code_next  = last_beat ? err_code : 2'd1;
                end else if (hs && last_beat) begin
                    state_next = DRAIN;
                    code_next  = 2'd2;
                end else if (timeout) begin
                    state_next = ERROR;
                    code_next  = 2'd3;
                end
            end
            HOLD:    if (ack) state_next = arm ? COLLECT : IDLE;
            DRAIN: begin
                if (hs && s_axis_c_tlast) begin
                    state_next = ERROR;
                end else if (timeout) begin
                    state_next = ERROR;
                    code_next  = 2'd3;
                end
            end
            ERROR: begin
                if (ack) begin
                    state_next = IDLE;
                    code_next  = 2'd0;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            err_code <= 2'd0;
        end else begin
            state    <= state_next;
            err_code <= code_next;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            beat_cnt <= '0;
            tile_cnt <= '0;
            rd_data  <= '0;
            for (int i = 0; i < NUM_BEATS; i++) bank[i] <= '0;
        end else begin
            if (state != COLLECT && state_next == COLLECT)
                beat_cnt <= '0;
            else if (state == COLLECT && hs)
                beat_cnt <= beat_cnt + AW'(1);
            // The beat that trips a length error is still stored
            if (state == COLLECT && hs)
                bank[beat_cnt] <= s_axis_c_tdata;
            if (state == COLLECT && state_next == HOLD)
                tile_cnt <= tile_cnt + CNT_W'(1);
            rd_data <= (32'(rd_addr) < NUM_BEATS) ? bank[rd_addr] : '0;
        end
    end
endmodule

// File: tb/tb_c_result_collector.sv
// tb_c_result_collector: table-driven directed bench for c_result_collector (CNT_W = 2 to exercise wrap).
module tb_c_result_collector;
    logic        clk, rst_n;
    logic [31:0] tdata;
    logic        tvalid, tready, tlast, arm, ack;
    logic [1:0]  rd_addr;
    logic [31:0] rd_data;
    logic        tile_done, err;
    logic [1:0]  err_code;
    logic [1:0]  tile_cnt;
    int          checks = 0;
    int          failures = 0;

    c_result_collector #(.DATA_W(32), .NUM_BEATS(4), .CNT_W(2), .TIMEOUT_CYC(8)) dut (
        .clk(clk), .rst_n(rst_n),
        .s_axis_c_tdata(tdata), .s_axis_c_tvalid(tvalid), .s_axis_c_tready(tready),
        .s_axis_c_tlast(tlast), .arm(arm), .ack(ack),
        .rd_addr(rd_addr), .rd_data(rd_data),
        .tile_done(tile_done), .err(err), .err_code(err_code), .tile_cnt(tile_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        arm, ack, v, last;
        logic [31:0] d;
        logic [1:0]  ra;
        logic        rdy, done, err;
        logic [1:0]  code, cnt;
        logic [31:0] rd;
    } vec_t;

    vec_t tbl[32];

    function automatic vec_t mk(input logic a, k, v, l, input logic [31:0] d, input logic [1:0] ra,
                                input logic rdy, dn, er, input logic [1:0] code, cnt, input logic [31:0] rd);
        vec_t t;
        t.arm = a; t.ack = k; t.v = v; t.last = l; t.d = d; t.ra = ra;
        t.rdy = rdy; t.done = dn; t.err = er; t.code = code; t.cnt = cnt; t.rd = rd;
        return t;
    endfunction

    task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", n, act, exp);
        end
    endtask

    task automatic check_out(input string n, input logic rdy, dn, er, input logic [1:0] code, cnt,
                             input logic [31:0] rd);
        chk({n, ".tready"}, 32'(tready), 32'(rdy));
        chk({n, ".tile_done"}, 32'(tile_done), 32'(dn));
        chk({n, ".err"}, 32'(err), 32'(er));
        chk({n, ".err_code"}, 32'(err_code), 32'(code));
        chk({n, ".tile_cnt"}, 32'(tile_cnt), 32'(cnt));
        chk({n, ".rd_data"}, rd_data, rd);
    endtask

    // Inputs are applied after a falling edge and outputs sampled at the next falling edge
    task automatic step(input logic a, k, v, l, input logic [31:0] d, input logic [1:0] ra);
        arm = a; ack = k; tvalid = v; tlast = l; tdata = d; rd_addr = ra;
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        rst_n = 1'b0; arm = 0; ack = 0; tvalid = 0; tlast = 0; tdata = 0; rd_addr = 0;
        repeat (2) @(negedge clk);
        check_out("reset", 0, 0, 0, 0, 0, 0);
        rst_n = 1'b1;

        // good tile, gapped tile, short tile, long tile
        tbl[0]  = mk(1,0,0,0,32'h0,   0, 1,0,0,0,0,32'h0);
        tbl[1]  = mk(0,0,1,0,32'h11,  0, 1,0,0,0,0,32'h0);
        tbl[2]  = mk(0,0,1,0,32'h22,  0, 1,0,0,0,0,32'h11);
        tbl[3]  = mk(0,0,1,0,32'h33,  1, 1,0,0,0,0,32'h22);
        tbl[4]  = mk(0,0,1,1,32'h44,  2, 0,1,0,0,1,32'h33);
        tbl[5]  = mk(0,0,0,0,32'h0,   3, 0,1,0,0,1,32'h44);
        tbl[6]  = mk(1,0,0,0,32'h0,   0, 0,1,0,0,1,32'h11);
        tbl[7]  = mk(0,1,0,0,32'h0,   1, 0,0,0,0,1,32'h22);
        tbl[8]  = mk(1,0,0,0,32'h0,   2, 1,0,0,0,1,32'h33);
        tbl[9]  = mk(0,0,1,0,32'h11,  0, 1,0,0,0,1,32'h11);
        tbl[10] = mk(0,0,0,1,32'hDEAD,0, 1,0,0,0,1,32'h11);
        tbl[11] = mk(0,0,0,0,32'hDEAD,0, 1,0,0,0,1,32'h11);
        tbl[12] = mk(0,0,1,0,32'h22,  1, 1,0,0,0,1,32'h22);
        tbl[13] = mk(0,0,0,0,32'h0,   1, 1,0,0,0,1,32'h22);
        tbl[14] = mk(0,0,1,0,32'h33,  2, 1,0,0,0,1,32'h33);
        tbl[15] = mk(0,0,0,0,32'h0,   3, 1,0,0,0,1,32'h44);
        tbl[16] = mk(0,0,1,1,32'h44,  0, 0,1,0,0,2,32'h11);
        tbl[17] = mk(0,1,0,0,32'h0,   3, 0,0,0,0,2,32'h44);
        tbl[18] = mk(0,0,1,1,32'h99,  0, 0,0,0,0,2,32'h11);
        tbl[19] = mk(1,0,0,0,32'h0,   0, 1,0,0,0,2,32'h11);
        tbl[20] = mk(0,0,1,0,32'hA,   0, 1,0,0,0,2,32'h11);
        tbl[21] = mk(0,0,1,1,32'hB,   0, 0,0,1,1,2,32'hA);
        tbl[22] = mk(1,0,0,0,32'h0,   1, 0,0,1,1,2,32'hB);
        tbl[23] = mk(0,1,0,0,32'h0,   2, 0,0,0,0,2,32'h33);
        tbl[24] = mk(1,0,0,0,32'h0,   0, 1,0,0,0,2,32'hA);
        tbl[25] = mk(0,0,1,0,32'h1,   0, 1,0,0,0,2,32'hA);
        tbl[26] = mk(0,0,1,0,32'h2,   0, 1,0,0,0,2,32'h1);
        tbl[27] = mk(0,0,1,0,32'h3,   1, 1,0,0,0,2,32'h2);
        tbl[28] = mk(0,0,1,0,32'h4,   2, 1,0,0,2,2,32'h3);
        tbl[29] = mk(0,0,1,0,32'h5,   3, 1,0,0,2,2,32'h4);
        tbl[30] = mk(0,0,1,1,32'h6,   0, 0,0,1,2,2,32'h1);
        tbl[31] = mk(0,1,0,0,32'h0,   3, 0,0,0,0,2,32'h4);

        for (int i = 0; i < 32; i++) begin
            step(tbl[i].arm, tbl[i].ack, tbl[i].v, tbl[i].last, tbl[i].d, tbl[i].ra);
            check_out($sformatf("vec%0d", i), tbl[i].rdy, tbl[i].done, tbl[i].err,
                      tbl[i].code, tbl[i].cnt, tbl[i].rd);
        end

        // back-to-back tiles via ack+arm in HOLD, tile_cnt wraps 3 -> 0
        step(1,0,0,0,0,0);
        for (int i = 0; i < 4; i++) step(0,0,1,i == 3,32'hC0 + 32'(i),0);
        chk("b2b.first_done", 32'(tile_done), 1);
        chk("b2b.cnt3", 32'(tile_cnt), 3);
        step(1,1,0,0,0,0);
        check_out("b2b.rearm", 1, 0, 0, 0, 3, 32'hC0);
        for (int i = 0; i < 4; i++) step(0,0,1,i == 3,32'hD0 + 32'(i),0);
        chk("b2b.second_done", 32'(tile_done), 1);
        chk("b2b.wrap", 32'(tile_cnt), 0);
        step(0,1,0,0,0,2);
        check_out("b2b.release", 0, 0, 0, 0, 0, 32'hD2);

        // stall after one beat
        step(1,0,0,0,0,0);
        step(0,0,1,0,32'h77,0);
        for (int i = 0; i < 7; i++) step(0,0,0,0,0,0);
        check_out("stall7", 1, 0, 0, 0, 0, 32'h77);
        step(0,0,0,0,0,0);
`ifdef C_COLLECT_TIMEOUT_EN
        check_out("timeout", 0, 0, 1, 3, 0, 32'h77);
`else
        check_out("no_timeout", 1, 0, 0, 0, 0, 32'h77);
        for (int i = 0; i < 20; i++) step(0,0,0,0,0,0);
        check_out("no_timeout_long", 1, 0, 0, 0, 0, 32'h77);
`endif

        // asynchronous reset mid-tile
        step(0,1,0,0,0,0);
        step(1,0,0,0,0,0);
        step(0,0,1,0,32'h99,0);
        chk("pre_reset.rd", rd_data, 32'h77);
        #2 rst_n = 1'b0;
        #1 check_out("async_reset", 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        rst_n = 1'b1;
        step(0,0,1,1,32'h5,0);
        check_out("post_reset", 0, 0, 0, 0, 0, 0);
        step(0,0,1,0,32'h6,1);
        check_out("post_reset2", 0, 0, 0, 0, 0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
